i2c_cmd_sequencer: RTL and testbench

- Upstream command stage for the I2C link: accepts one command (opcode plus two 32-bit operands) over a valid/ready handshake.
- Drives i2c_master_controller to send the three words in order (opcode, op_a, op_b) to the slave-side processing FSM.
- Paces the words with a programmable inter-word gap so the slave receiver and processing FSM finish each word before the next one arrives.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_cmd_sequencer_if.sv | 26 ++
 rtl/i2c_gap_timer.sv | 28 ++
 rtl/i2c_cmd_sequencer.sv | 127 ++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command sequencer: FSM encodings and
// the command framing constants.
package i2c_pkg;

  localparam int         NUM_WORDS          = 3;
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h2A;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5,
    ST_FINISH    = 3'd6
  } state_t;

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Command handshake plus the word-level link to i2c_master_controller.
// cmd: a transfer happens on a clk edge where cmd_valid && cmd_ready; the
// source holds cmd_valid and the words stable until then. m_*: m_enable is
// held with stable m_data until the master drops m_ready (word accepted).
interface i2c_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_opcode;
  logic [31:0] cmd_op_a;
  logic [31:0] cmd_op_b;
  logic [6:0]  m_addr;
  logic [31:0] m_data;
  logic        m_enable;
  logic        m_rw;
  logic        m_ready;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b, m_ready,
    output cmd_ready, m_addr, m_data, m_enable, m_rw
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b, m_ready,
    input  cmd_ready, m_addr, m_data, m_enable, m_rw
  );
endinterface

// File: rtl/i2c_gap_timer.sv
// Loadable down-counter that stops at zero; used for inter-word gaps and
// for the master handshake timeout.
module i2c_gap_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Accepts one three-word command and feeds the words to the I2C master
// one at a time, with a fixed idle gap after each completed word.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR    = DEFAULT_SLAVE_ADDR,
  parameter int         GAP_CYCLES    = 64,
  parameter int         START_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  i2c_cmd_sequencer_if.master        bus,
  output logic                       busy,
  output logic [1:0]                 word_idx,
  output logic                       done,
  output logic                       err,
  output logic [2:0]                 state_out
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  // Timers are loaded with N-1 so a zero flag marks the Nth cycle of the wait.
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(START_TIMEOUT - 1);
  localparam logic [1:0]    LAST_IDX = 2'(NUM_WORDS - 1);

  state_t      state, next;
  logic [31:0] opcode_q, op_a_q, op_b_q;
  logic [31:0] data_q;
  logic [31:0] sel_word;
  logic [1:0]  idx;
  logic        err_q;
  logic        abort;
  logic        gap_zero, to_zero;
  logic        in_wait;

  assign in_wait = (state == ST_WAIT_IDLE) || (state == ST_WAIT_BUSY);

  i2c_gap_timer #(.WIDTH(GW)) u_gap (
    .clk(clk), .rst(rst), .load(state != ST_GAP), .load_val(GAP_LOAD),
    .dec(state == ST_GAP), .zero(gap_zero)
  );

  i2c_gap_timer #(.WIDTH(TW)) u_timeout (
    .clk(clk), .rst(rst), .load(!in_wait), .load_val(TO_LOAD),
    .dec(in_wait), .zero(to_zero)
  );

  always_comb begin
    sel_word = opcode_q;
    case (idx)
      2'd1:    sel_word = op_a_q;
      2'd2:    sel_word = op_b_q;
      default: sel_word = opcode_q;
    endcase
  end

  always_comb begin
    next  = state;
    abort = 1'b0;
    case (state)
      ST_IDLE:      if (bus.cmd_valid) next = ST_WAIT_IDLE;
      ST_WAIT_IDLE: begin
        if (bus.m_ready) begin
          next = ST_START;
        end else if (to_zero) begin
          abort = 1'b1;
          next  = ST_IDLE;
        end
      end
      ST_START:     next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!bus.m_ready) begin
          next = ST_WAIT_DONE;
        end else if (to_zero) begin
          abort = 1'b1;
          next  = ST_IDLE;
        end
      end
      ST_WAIT_DONE: if (bus.m_ready) next = ST_GAP;
      ST_GAP: begin
        if (gap_zero) next = (idx == LAST_IDX) ? ST_FINISH : ST_WAIT_IDLE;
      end
      ST_FINISH:    next = ST_IDLE;
      default:      next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      idx    <= 2'd0;
      data_q <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      state <= next;
      err_q <= abort;
      if ((state == ST_IDLE) && bus.cmd_valid) begin
        idx <= 2'd0;
      end else if ((state == ST_GAP) && gap_zero && (idx != LAST_IDX)) begin
        idx <= idx + 2'd1;
      end
      // Loaded on entry to START so the word is valid while m_enable rises.
      if (next == ST_START) data_q <= sel_word;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && bus.cmd_valid) begin
      opcode_q <= bus.cmd_opcode;
      op_a_q   <= bus.cmd_op_a;
      op_b_q   <= bus.cmd_op_b;
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.m_addr    = SLAVE_ADDR;
  assign bus.m_rw      = 1'b0;
  assign bus.m_data    = data_q;
  assign bus.m_enable  = (state == ST_START) || (state == ST_WAIT_BUSY);
  assign busy          = (state != ST_IDLE);
  assign word_idx      = idx;
  assign done          = (state == ST_FINISH);
  assign err           = err_q;
  assign state_out     = state;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: behavioural I2C master, word scoreboard,
// and timing checks on gaps, timeouts and reset.
module tb_i2c_cmd_sequencer;

  localparam int GAP = 10;
  localparam int TO  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy, done, err;
  logic [1:0] word_idx;
  logic [2:0] state_out;

  i2c_cmd_sequencer_if bus ();

  i2c_cmd_sequencer #(.SLAVE_ADDR(7'h2A), .GAP_CYCLES(GAP), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .word_idx(word_idx),
    .done(done), .err(err), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // scoreboard / monitor state
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [1:0]  idx_q[$];
  int          en_len_q[$];
  int          gap_q[$];
  int          wi_q[$];
  int en_rises, done_cnt, err_cnt, pulse_wide, stab_err, data_moved;
  int en_len, gap_len, wi_len;
  logic        prev_en, done_prev, err_prev;
  logic [31:0] en_data, prev_data;
  logic [3:0]  err_state;

  // master model controls: 0 normal, 1 never accepts, 2 never idle
  int master_mode = 0;
  int xfer_min = 40;
  int xfer_max = 40;

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (master_mode == 1) begin
        bus.m_ready = 1'b1;
      end else if (master_mode == 2) begin
        bus.m_ready = 1'b0;
      end else if (bus.m_enable) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        got_q.push_back(bus.m_data);
        bus.m_ready = 1'b0;
        repeat ($urandom_range(xfer_max, xfer_min)) @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
      end else begin
        bus.m_ready = 1'b1;
      end
    end
  end

  initial begin
    prev_en = 1'b0; done_prev = 1'b0; err_prev = 1'b0;
    en_len = 0; gap_len = 0; wi_len = 0; prev_data = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.m_enable) begin
        if (!prev_en) begin
          en_rises++;
          idx_q.push_back(word_idx);
          en_data = bus.m_data;
          en_len  = 0;
        end else if (bus.m_data !== en_data) begin
          stab_err++;
        end
        en_len++;
      end else begin
        if (prev_en) en_len_q.push_back(en_len);
        if (bus.m_data !== prev_data) data_moved++;
      end
      prev_en   = bus.m_enable;
      prev_data = bus.m_data;
      if (done === 1'b1) begin
        if (done_prev) pulse_wide++; else done_cnt++;
      end
      if (err === 1'b1) begin
        if (err_prev) pulse_wide++;
        else begin
          err_cnt++;
          err_state = {bus.cmd_ready, state_out};
        end
      end
      done_prev = (done === 1'b1);
      err_prev  = (err === 1'b1);
      if (state_out === 3'd5) gap_len++;
      else if (gap_len != 0) begin gap_q.push_back(gap_len); gap_len = 0; end
      if (state_out === 3'd1) wi_len++;
      else if (wi_len != 0) begin wi_q.push_back(wi_len); wi_len = 0; end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    exp_q.delete(); got_q.delete(); idx_q.delete();
    en_len_q.delete(); gap_q.delete(); wi_q.delete();
    en_rises = 0; done_cnt = 0; err_cnt = 0; pulse_wide = 0;
    stab_err = 0; data_moved = 0; err_state = 4'h0;
  endtask

  task automatic send_cmd(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (ok) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_opcode = w0; bus.cmd_op_a = w1; bus.cmd_op_b = w2;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2);
    end
  endtask

  // which: 0 waits for done pulses, 1 for err pulses
  task automatic wait_evt(input int which, input int n, input int budget, output bit ok);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (((which == 0) ? done_cnt : err_cnt) >= n) break;
    end
    ok = (((which == 0) ? done_cnt : err_cnt) >= n);
  endtask

  task automatic test_reset();
    logic [49:0] exp_v, got_v;
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_opcode = '0; bus.cmd_op_a = '0; bus.cmd_op_b = '0;
    repeat (3) @(negedge clk);
    exp_v = {1'b1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 3'd0, 7'h2A, 1'b0};
    got_v = {bus.cmd_ready, busy, bus.m_enable, bus.m_data, word_idx, done, err,
             state_out, bus.m_addr, bus.m_rw};
    tests_run++;
    if (got_v !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_values: got %h expected %h", got_v, exp_v);
    end
    rst = 1'b1;
    @(negedge clk);
    clear_mon();
  endtask

  task automatic test_basic();
    bit ok;
    logic [31:0] e, g;
    clear_mon();
    xfer_min = 40; xfer_max = 40;
    send_cmd(32'h0000_0000, 32'h1234_5678, 32'hA0B0_C0D1, ok);
    wait_evt(0, 1, 3000, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL basic_done_timeout: done_cnt %0d expected 1", done_cnt); end
    @(negedge clk);
    tests_run++;
    if ({bus.cmd_ready, busy} !== 2'b10) begin
      tests_failed++; $display("FAIL basic_ready_after_done: ready/busy %b expected 10", {bus.cmd_ready, busy});
    end
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL basic_word%0d: got %h expected %h", i, g, e); end
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ((i >= idx_q.size()) || (idx_q[i] !== 2'(i)) || (i >= en_len_q.size()) || (en_len_q[i] != 3)) begin
        tests_failed++;
        $display("FAIL basic_word_idx_enable%0d: idx %0d len %0d expected idx %0d len 3", i,
                 (i < idx_q.size()) ? idx_q[i] : 2'd3, (i < en_len_q.size()) ? en_len_q[i] : -1, i);
      end
    end
    tests_run++;
    if (en_rises != 3 || done_cnt != 1 || err_cnt != 0 || pulse_wide != 0) begin
      tests_failed++;
      $display("FAIL basic_counts: enables %0d done %0d err %0d wide %0d expected 3 1 0 0",
               en_rises, done_cnt, err_cnt, pulse_wide);
    end
    tests_run++;
    if (stab_err != 0 || data_moved != 0) begin
      tests_failed++; $display("FAIL basic_data_stable: unstable %0d moved %0d expected 0 0", stab_err, data_moved);
    end
  endtask

  task automatic test_gap_random();
    bit ok;
    logic [31:0] e, g;
    clear_mon();
    xfer_min = 3; xfer_max = 30;
    for (int n = 0; n < 4; n++) begin
      send_cmd($urandom, $urandom, $urandom, ok);
      wait_evt(0, n + 1, 3000, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL gap_done_timeout: cmd %0d done_cnt %0d", n, done_cnt); end
    end
    for (int i = 0; i < 12; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL random_word%0d: got %h expected %h", i, g, e); end
    end
    tests_run++;
    if (gap_q.size() != 12 || wi_q.size() != 12) begin
      tests_failed++; $display("FAIL gap_count: gaps %0d waits %0d expected 12 12", gap_q.size(), wi_q.size());
    end
    for (int i = 0; i < gap_q.size(); i++) begin
      tests_run++;
      if (gap_q[i] != GAP || (i < wi_q.size() && wi_q[i] != 1)) begin
        tests_failed++;
        $display("FAIL gap_len%0d: gap %0d wait_idle %0d expected %0d 1", i, gap_q[i],
                 (i < wi_q.size()) ? wi_q[i] : -1, GAP);
      end
    end
    tests_run++;
    if (err_cnt != 0 || stab_err != 0 || data_moved != 0 || pulse_wide != 0) begin
      tests_failed++;
      $display("FAIL random_clean: err %0d unstable %0d moved %0d wide %0d expected 0", err_cnt, stab_err, data_moved, pulse_wide);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] e, g, b1, b2;
    clear_mon();
    xfer_min = 5; xfer_max = 20;
    b1 = $urandom; b2 = $urandom;
    send_cmd($urandom, $urandom, $urandom, ok);
    @(negedge clk); @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_opcode = 32'h1; bus.cmd_op_a = b1; bus.cmd_op_b = b2;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
    tests_run++;
    if (!ok || done_cnt != 1) begin
      tests_failed++; $display("FAIL b2b_accept_after_done: ready %0d done_cnt %0d expected 1 1", ok, done_cnt);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    exp_q.push_back(32'h1); exp_q.push_back(b1); exp_q.push_back(b2);
    wait_evt(0, 2, 3000, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL b2b_done_timeout: done_cnt %0d expected 2", done_cnt); end
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL b2b_word%0d: got %h expected %h", i, g, e); end
    end
    tests_run++;
    if (got_q.size() != 0 || err_cnt != 0) begin
      tests_failed++; $display("FAIL b2b_extra: extra words %0d err %0d expected 0 0", got_q.size(), err_cnt);
    end
  endtask

  task automatic test_accept_timeout();
    bit ok;
    clear_mon();
    master_mode = 1;
    send_cmd($urandom, $urandom, $urandom, ok);
    wait_evt(1, 1, 500, ok);
    repeat (5) @(negedge clk);
    tests_run++;
    if (!ok || err_cnt != 1 || done_cnt != 0 || pulse_wide != 0) begin
      tests_failed++; $display("FAIL acc_to_err: err %0d done %0d wide %0d expected 1 0 0", err_cnt, done_cnt, pulse_wide);
    end
    tests_run++;
    if (en_rises != 1 || en_len_q.size() != 1 || (en_len_q.size() == 1 && en_len_q[0] != TO + 1)) begin
      tests_failed++;
      $display("FAIL acc_to_enable: rises %0d len %0d expected 1 %0d", en_rises,
               (en_len_q.size() > 0) ? en_len_q[0] : -1, TO + 1);
    end
    tests_run++;
    if (err_state !== 4'b1000) begin
      tests_failed++; $display("FAIL acc_to_idle: ready/state %b expected 1000", err_state);
    end
    master_mode = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_idle_timeout();
    bit ok;
    master_mode = 2;
    repeat (3) @(negedge clk);
    clear_mon();
    send_cmd($urandom, $urandom, $urandom, ok);
    wait_evt(1, 1, 500, ok);
    repeat (5) @(negedge clk);
    tests_run++;
    if (!ok || err_cnt != 1 || done_cnt != 0 || en_rises != 0) begin
      tests_failed++; $display("FAIL idle_to_err: err %0d done %0d enables %0d expected 1 0 0", err_cnt, done_cnt, en_rises);
    end
    tests_run++;
    if (wi_q.size() != 1 || (wi_q.size() == 1 && wi_q[0] != TO) || err_state !== 4'b1000) begin
      tests_failed++;
      $display("FAIL idle_to_wait: wait_idle %0d state %b expected %0d 1000",
               (wi_q.size() > 0) ? wi_q[0] : -1, err_state, TO);
    end
    master_mode = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [31:0] e, g;
    logic [49:0] exp_v, got_v;
    clear_mon();
    xfer_min = 30; xfer_max = 30;
    send_cmd($urandom, $urandom, $urandom, ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (word_idx === 2'd1 && state_out === 3'd4) begin ok = 1'b1; break; end
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL rstmid_reach: word_idx %0d state %0d expected 1 4", word_idx, state_out); end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    exp_v = {1'b1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 3'd0, 7'h2A, 1'b0};
    got_v = {bus.cmd_ready, busy, bus.m_enable, bus.m_data, word_idx, done, err,
             state_out, bus.m_addr, bus.m_rw};
    tests_run++;
    if (got_v !== exp_v) begin tests_failed++; $display("FAIL rstmid_values: got %h expected %h", got_v, exp_v); end
    clear_mon();
    repeat (60) @(negedge clk);
    tests_run++;
    if (done_cnt != 0 || err_cnt != 0 || en_rises != 0) begin
      tests_failed++; $display("FAIL rstmid_quiet: done %0d err %0d enables %0d expected 0 0 0", done_cnt, err_cnt, en_rises);
    end
    for (int c = 0; c < 200 && bus.m_ready !== 1'b1; c++) @(negedge clk);
    clear_mon();
    send_cmd(32'hC0DE_0001, $urandom, $urandom, ok);
    wait_evt(0, 1, 3000, ok);
    tests_run++;
    if (!ok || err_cnt != 0) begin tests_failed++; $display("FAIL rstmid_new_cmd: done %0d err %0d expected 1 0", done_cnt, err_cnt); end
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL rstmid_word%0d: got %h expected %h", i, g, e); end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    test_reset();
    test_basic();
    test_gap_random();
    test_back_to_back();
    test_accept_timeout();
    test_idle_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
